// File: rtl/peripheral_pkg.sv
// Shared types and constants for the board peripheral blocks (button, switches, decoder).
package peripheral_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam logic [31:0] ENTER_ADDR = 32'hC000_0010;

endpackage

// File: rtl/peripheral_button_conditioner_sync_ff.sv
// Multi-flop synchronizer for asynchronous board inputs; the reset value lets each
// pin start at its idle level so no false edge is seen when reset deasserts.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/peripheral_button_conditioner.sv
// Push-button conditioner: synchronize, debounce, pulse, sticky flag and press counter.
// Optional auto-repeat while held is built only when BTN_AUTOREPEAT_EN is defined.
module peripheral_button_conditioner
    import peripheral_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ack,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic       btn_sticky,
    output logic [7:0] press_count
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_PIN = logic'(ACTIVE_LOW != 0);

    logic       pin_sync;
    logic       s;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       pulse_q, pulse_d;
    logic       sticky_q, sticky_d;
    logic [7:0] count_q, count_d;
    logic       press_acc;
    logic       rep_fire;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_PIN)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_raw),
        .q_o   (pin_sync)
    );

    // s = 1 while pressed, independent of pin polarity
    assign s = pin_sync ^ IDLE_PIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RELEASED;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    // The counter stops at CNT_LAST, so it can never wrap while arming.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ARM_PRESS: begin
                if (!s)                     state_d = RELEASED;
                else if (cnt_q == CNT_LAST) state_d = PRESSED;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            PRESSED: begin
                if (!s) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = '0;
                end
            end
            ARM_RELEASE: begin
                if (s)                      state_d = PRESSED;
                else if (cnt_q == CNT_LAST) state_d = RELEASED;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = RELEASED;
        endcase
    end

    // Sticky and counter follow the registered pulse, so ack never masks a press.
    always_comb begin
        press_acc = (state_q == ARM_PRESS) && (state_d == PRESSED);
        level_d   = (state_d == PRESSED) || (state_d == ARM_RELEASE);
        pulse_d   = press_acc | rep_fire;
        sticky_d  = pulse_q | (sticky_q & ~ack);
        count_d   = count_q + {7'd0, pulse_q};
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_armed_q, rep_armed_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    // Runs in PRESSED, holds through ARM_RELEASE, clears once the press is over.
    always_comb begin
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (state_q == PRESSED) begin
            if (rep_q == (rep_armed_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                rep_fire    = 1'b1;
                rep_d       = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end else if (state_q != ARM_RELEASE) begin
            rep_d       = '0;
            rep_armed_d = 1'b0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_sticky  = sticky_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_peripheral_button_conditioner.sv
// Self-checking bench for peripheral_button_conditioner; honours BTN_AUTOREPEAT_EN.
module tb_peripheral_button_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int ALOW = 1;
    localparam int RDLY = 10;
    localparam int RPER = 3;
    localparam logic REL = (ALOW != 0);
    localparam logic PRS = (ALOW == 0);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = REL;
    logic       ack = 1'b0;
    logic       btn_level, btn_pulse, btn_sticky;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_bad = 0;

    peripheral_button_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (ALOW),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .ack         (ack),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_sticky  (btn_sticky),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Reference: the level flips once DEB+1 consecutive synchronized samples disagree with it.
    bit [SYNC-1:0] m_hist = '0;
    int            m_run = 0;
    int            m_t = 0;
    bit            m_lvl = 0, m_pulse = 0, m_sticky = 0;
    bit [7:0]      m_cnt = 0;

    always @(posedge clk) begin : model
        bit s, fire, lvl0;
        int run0;
        if (reset) begin
            m_hist = '0; m_run = 0; m_t = 0;
            m_lvl = 0; m_pulse = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            s    = m_hist[SYNC-1];
            lvl0 = m_lvl;
            run0 = m_run;
            fire = 0;
            m_sticky = m_pulse | (m_sticky & ~ack);
            m_cnt    = m_cnt + 8'(m_pulse);
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = s;
                    m_run = 0;
                    fire  = s;
                    if (!s) m_t = 0;
                end
            end else begin
                m_run = 0;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (lvl0 && run0 == 0) begin
                m_t++;
                if (m_t >= RDLY && ((m_t - RDLY) % RPER) == 0) fire = 1;
            end
`endif
            m_pulse = fire;
            m_hist  = {m_hist[SYNC-2:0], btn_raw ^ REL};
        end
    end

    task automatic test_reset();
        int rise = -1;
        reset = 1; btn_raw = PRS; ack = 0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_outputs got=%h want=0", {btn_level, btn_pulse, btn_sticky, press_count});
            end
        end
        reset = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                n_bad++;
                $display("FAIL reset_model k=%0d got=%h want=%h", k,
                         {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
            end
            if (btn_level && rise < 0) rise = k;
        end
        n_cmp++;
        if (rise != SYNC + DEB + 1) begin n_bad++; $display("FAIL reset_latency got=%0d want=%0d", rise, SYNC + DEB + 1); end
        n_cmp++;
        if (press_count !== 8'd1) begin n_bad++; $display("FAIL reset_count got=%0d want=1", press_count); end
        btn_raw = REL;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int pk = -1, np = 0, fall = -1;
        btn_raw = PRS;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                n_bad++;
                $display("FAIL press_model k=%0d got=%h want=%h", k,
                         {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
            end
            if (btn_pulse) begin np++; if (pk < 0) pk = k; end
        end
        n_cmp++;
        if (pk != 7 || np != 1) begin n_bad++; $display("FAIL press_pulse edge=%0d count=%0d want edge=7 count=1", pk, np); end
        n_cmp++;
        if (btn_sticky !== 1'b1 || btn_level !== 1'b1) begin
            n_bad++; $display("FAIL press_held sticky=%b level=%b want 1 1", btn_sticky, btn_level);
        end
        btn_raw = REL;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                n_bad++;
                $display("FAIL release_model k=%0d got=%h want=%h", k,
                         {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
            end
            if (!btn_level && fall < 0) fall = k;
        end
        n_cmp++;
        if (fall != 7) begin n_bad++; $display("FAIL release_latency got=%0d want=7", fall); end
    endtask

    task automatic test_bounce();
        int np = 0, nl = 0;
        logic [7:0] c0 = press_count;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                btn_raw = (j < 3) ? PRS : REL;
                @(negedge clk);
                n_cmp++;
                if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                    n_bad++;
                    $display("FAIL bounce_model r=%0d got=%h want=%h", r,
                             {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
                end
                np += int'(btn_pulse); nl += int'(btn_level);
            end
        end
        btn_raw = REL;
        repeat (10) begin
            @(negedge clk);
            np += int'(btn_pulse); nl += int'(btn_level);
        end
        n_cmp++;
        if (np != 0 || nl != 0 || press_count !== c0) begin
            n_bad++;
            $display("FAIL bounce_reject pulses=%0d level_cycles=%0d count=%0d want 0 0 %0d", np, nl, press_count, c0);
        end
    endtask

    task automatic test_sticky_ack();
        bit hit = 0;
        logic [7:0] c0;
        ack = 1;
        @(negedge clk);
        ack = 0;
        n_cmp++;
        if (btn_sticky !== 1'b0) begin n_bad++; $display("FAIL ack_clear got=%b want=0", btn_sticky); end
        c0 = press_count;
        ack = 1;
        @(negedge clk);
        ack = 0;
        @(negedge clk);
        n_cmp++;
        if (btn_sticky !== 1'b0 || press_count !== c0) begin
            n_bad++; $display("FAIL ack_idle sticky=%b count=%0d want 0 %0d", btn_sticky, press_count, c0);
        end
        btn_raw = PRS;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (btn_pulse) begin hit = 1; ack = 1; end
        end
        @(negedge clk);
        ack = 0;
        n_cmp++;
        if (!hit || btn_sticky !== 1'b1) begin
            n_bad++; $display("FAIL ack_vs_pulse seen=%0d sticky=%b want 1 1", hit, btn_sticky);
        end
        btn_raw = REL;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        btn_raw = PRS;
        repeat (4) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({btn_level, btn_pulse, btn_sticky, press_count} !== 11'd0) begin
            n_bad++; $display("FAIL midreset_outputs got=%h want=0", {btn_level, btn_pulse, btn_sticky, press_count});
        end
        reset = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                n_bad++;
                $display("FAIL midreset_model k=%0d got=%h want=%h", k,
                         {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
            end
            if (btn_level && rise < 0) rise = k;
        end
        n_cmp++;
        if (rise != 7) begin n_bad++; $display("FAIL midreset_latency got=%0d want=7", rise); end
        btn_raw = REL;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_autorepeat();
        int q[$];
        int w[$];
        int k0 = -1;
        w.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
        for (int o = RDLY; o <= 30; o += RPER) w.push_back(o);
`endif
        btn_raw = PRS;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                n_bad++;
                $display("FAIL repeat_model k=%0d got=%h want=%h", k,
                         {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
            end
            if (btn_pulse) begin
                if (k0 < 0) k0 = k;
                q.push_back(k - k0);
            end
            if (k0 >= 0 && k == k0 + 30) break;
        end
        n_cmp++;
        if (q.size() != w.size()) begin
            n_bad++; $display("FAIL repeat_count got=%0d want=%0d", q.size(), w.size());
        end else begin
            foreach (w[i]) begin
                n_cmp++;
                if (q[i] != w[i]) begin n_bad++; $display("FAIL repeat_offset i=%0d got=%0d want=%0d", i, q[i], w[i]); end
            end
        end
        btn_raw = REL;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_wrap();
        int np = 0, h, g;
        reset = 1; btn_raw = REL; ack = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int p = 0; p < 256; p++) begin
            h = $urandom_range(5, 9);
            g = $urandom_range(6, 10);
            for (int j = 0; j < h + g; j++) begin
                btn_raw = (j < h) ? PRS : REL;
                ack = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                n_cmp++;
                if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                    n_bad++;
                    $display("FAIL wrap_model p=%0d got=%h want=%h", p,
                             {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
                end
                np += int'(btn_pulse);
            end
        end
        ack = 0; btn_raw = REL;
        repeat (4) begin @(negedge clk); np += int'(btn_pulse); end
        n_cmp++;
        if (np != 256 || press_count !== 8'd0) begin
            n_bad++; $display("FAIL wrap pulses=%0d count=%0d want 256 0", np, press_count);
        end
    endtask

    task automatic test_random();
        int run;
        for (int c = 0; c < 1500; ) begin
            btn_raw = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
            for (int j = 0; j < run; j++, c++) begin
                ack = ($urandom_range(0, 5) == 0);
                @(negedge clk);
                n_cmp++;
                if ({btn_level, btn_pulse, btn_sticky, press_count} !== {m_lvl, m_pulse, m_sticky, m_cnt}) begin
                    n_bad++;
                    $display("FAIL random_model c=%0d got=%h want=%h", c,
                             {btn_level, btn_pulse, btn_sticky, press_count}, {m_lvl, m_pulse, m_sticky, m_cnt});
                end
            end
        end
        ack = 0; btn_raw = REL;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sticky_ack();
        test_reset_mid();
        test_autorepeat();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
